serial_xmit: RTL and testbench
==============================

# serial_xmit

Parametrised asynchronous serial transmitter, the successor to the fixed-format Teletype transmitter card. It accepts characters from the IOT/bus side into a small FIFO and shifts them out LSB-first on `txd`. Data width, parity, stop-bit length and bit rate are configurable, and a done flag is raised per character. It sits between the IOT decode logic and the line driver, and runs entirely on the system `clk`, with an internal bit-rate divider replacing the external baud clock.

## Interface
Parameters:
- `DATA_BITS`, 8: character width, legal 5..8.
- `FIFO_DEPTH`, 4: character buffer depth, a power of 2, ≥2.
- `DIV_W`, 16: width of the bit-rate divisor.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `baud_div` in DIV_W: bit time = `baud_div`+1 clk cycles. Values below 1 are illegal.
- `stop_sel` in 2: 00 = 1 stop bit, 01 = 1.5, 10 = 2, 11 = 2.
- `parity_mode` in 2: 00 = none, 01 = even, 10 = odd, 11 = mark (always 1).
- `wr_en` in 1: write strobe, one character per cycle.
- `wr_data` in DATA_BITS: character to enqueue.
- `flag_clr` in 1: clears `flag` and `ovf`.
- `txd` out 1: serial line; idles at 1 (mark).
- `active` out 1: character in progress (state ≠ IDLE).
- `full` out 1: FIFO count = FIFO_DEPTH.
- `empty` out 1: FIFO count = 0.
- `flag` out 1: sticky; set when a character's final stop bit completes.
- `ovf` out 1: sticky; set when `wr_en` arrives while `full`.

## Operation
- **Reset values:** `txd`=1, `active`=0, `full`=0, `empty`=1, `flag`=0, `ovf`=0. FIFO pointers and bit counters are zeroed and the state is IDLE. Reset mid-character aborts it immediately, with no trailing stop bit.
- **FIFO write:** a write is accepted iff `full` is 0 at the start of the cycle. A write while `full` is dropped and sets `ovf`, even if a pop occurs in the same cycle. A simultaneous write and pop on a non-full FIFO leaves the count unchanged.
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - In IDLE with `empty`=0: pop the FIFO, load the shifter, and latch `baud_div`, `stop_sel` and `parity_mode` for this character. Move to START.
  - START drives 0 for one bit time.
  - DATA drives `DATA_BITS` bits, LSB first, one bit time each.
  - PARITY is skipped when `parity_mode`=00. Otherwise it drives one bit time of the computed parity over the data bits.
  - STOP drives 1 for the stop length:
    - 1 stop: 1 bit time.
    - 2 stop: 2 bit times.
    - 1.5 stop: 1 bit time + floor((`baud_div`+1)/2) cycles.
- **End of character:** at the end of STOP the block returns to IDLE and sets `flag`.
  - If the FIFO is non-empty in that same IDLE cycle, the next pop happens then. Characters are separated only by their stop time, with no extra idle bit.
- **Flag priority:** if `flag_clr` and a flag-set event occur in the same cycle, the set wins. `ovf` follows the same rule.
- **Mid-character changes:** changing `baud_div`, `stop_sel` or `parity_mode` mid-character has no effect until the next pop.

## Timing
- `txd`, `active`, `flag`, `full`, `empty` and `ovf` are all registered outputs.
- Write to an idle, empty block at edge W: `empty` falls after W. The pop happens in the cycle after W, and `txd` goes low after edge W+1 (2-clock latency).
- Each bit holds `txd` for exactly `baud_div`+1 cycles. The divider reloads at every bit boundary.
- Frame length in clk cycles = (1 + DATA_BITS + P)·(`baud_div`+1) + stop cycles, where P = 0 or 1.
- `flag` rises on the same edge that `txd` enters its next start bit or returns to idle.

## Structure
- Package `serial_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - the `STOP_*` and `PAR_*` 2-bit constants;
  - a width-checked `clog2` helper.
- One sub-module, `sync_fifo` (parameters WIDTH and DEPTH), provides `full`/`empty` and a first-word-fall-through read. The shifter and divider live in `serial_xmit`.

## Test plan
- **8N1:** `baud_div`=3, write 0x55. `txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; low starts 2 clocks after the write; `flag` rises after 40 cycles of frame.
- **7E2:** `DATA_BITS`=7, `parity_mode`=01, `stop_sel`=10, `baud_div`=1, write 0x03. Bits are 0, 1100000, parity 0, then 1,1; frame = 22 cycles.
- **1.5 stop, odd parity:** `baud_div`=4, write 0x00. Parity bit = 1; stop high for 5+2 = 7 cycles before `flag`.
- **FIFO full:** write 5 characters back-to-back, DEPTH=4, while one character is shifting.
  - The 5th is dropped and `ovf`=1.
  - Frames are contiguous with no idle gap; `empty`=1 after the last pop.
- **Reset mid-DATA:** assert `rst` during bit 3. `txd`=1 immediately (asynchronous) and `empty`=1; after release, no output until the next write.
- **Flag collision:** `flag_clr` on the edge ending a stop bit leaves `flag`=1. A later `flag_clr` pulse clears it to 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the serial transmitter: FSM encoding, stop/parity codes,
// and a clog2 helper for sizing counters and pointers.
package serial_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_15  = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;
    localparam logic [1:0] STOP_2B  = 2'b11;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    // Never returns less than 1 so a value of 1 still yields a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_xmit_fifo.sv
// Character buffer with registered full/empty flags and first-word-fall-through read.
module sync_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;

    assign w_push      = i_wr_en && !r_full;
    assign w_pop       = i_rd_en && !r_empty;
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
endmodule

// File: rtl/serial_xmit.sv
// Async serial transmitter: FIFO-fed, LSB-first, programmable parity/stop/bit rate.
//   state     | meaning
//   ST_IDLE   | line at mark, waiting for a buffered character
//   ST_START  | driving the 0 start bit
//   ST_DATA   | shifting DATA_BITS data bits, LSB first
//   ST_PARITY | driving the computed parity bit (skipped for no parity)
//   ST_STOP   | driving 1 for 1, 1.5 or 2 bit times
module serial_xmit
    import serial_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           stop_sel,
    input  logic [1:0]           parity_mode,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 flag_clr,
    output logic                 txd,
    output logic                 active,
    output logic                 full,
    output logic                 empty,
    output logic                 flag,
    output logic                 ovf
);
    localparam int BIT_W = clog2(DATA_BITS);

    logic [2:0]           r_state;
    logic                 r_txd;
    logic                 r_active;
    logic                 r_flag;
    logic                 r_ovf;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [DIV_W-1:0]     r_bd;
    logic [1:0]           r_stop;
    logic [1:0]           r_par;
    logic                 r_par_bit;
    logic                 r_stop_ph;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_tick;
    logic                 w_stop_last;
    logic                 w_frame_end;
    logic                 w_pop;
    logic                 w_par_bit;
    logic [DIV_W-1:0]     w_half_m1;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (full),
        .o_empty   (empty)
    );

    assign w_tick      = (r_div_cnt == '0);
    assign w_stop_last = r_stop_ph || (r_stop == STOP_1);
    assign w_frame_end = (r_state == ST_STOP) && w_tick && w_stop_last;
    // Popping on the frame-end edge keeps back-to-back characters gapless.
    assign w_pop       = !empty && ((r_state == ST_IDLE) || w_frame_end);
    // floor((bd+1)/2) - 1 rewritten so it cannot overflow DIV_W (bd >= 1).
    assign w_half_m1   = (r_bd - DIV_W'(1)) >> 1;

    always_comb begin
        w_par_bit = 1'b0;
        case (parity_mode)
            PAR_EVEN: w_par_bit = ^w_fifo_data;
            PAR_ODD:  w_par_bit = ~^w_fifo_data;
            PAR_MARK: w_par_bit = 1'b1;
            default:  w_par_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
            r_active  <= 1'b0;
            r_flag    <= 1'b0;
            r_ovf     <= 1'b0;
            r_div_cnt <= '0;
            r_bd      <= '0;
            r_stop    <= STOP_1;
            r_par     <= PAR_NONE;
            r_par_bit <= 1'b0;
            r_stop_ph <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_pop) begin
                r_state   <= ST_START;
                r_txd     <= 1'b0;
                r_active  <= 1'b1;
                r_div_cnt <= baud_div;
                r_bd      <= baud_div;
                r_stop    <= stop_sel;
                r_par     <= parity_mode;
                r_par_bit <= w_par_bit;
                r_shift   <= w_fifo_data;
                r_bit_cnt <= '0;
                r_stop_ph <= 1'b0;
            end else begin
                if (r_state != ST_IDLE)
                    r_div_cnt <= w_tick ? r_bd : r_div_cnt - DIV_W'(1);
                case (r_state)
                    ST_START: if (w_tick) begin
                        r_state   <= ST_DATA;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                    end
                    ST_DATA: if (w_tick) begin
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            if (r_par == PAR_NONE) begin
                                r_state <= ST_STOP;
                                r_txd   <= 1'b1;
                            end else begin
                                r_state <= ST_PARITY;
                                r_txd   <= r_par_bit;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                    ST_PARITY: if (w_tick) begin
                        r_state <= ST_STOP;
                        r_txd   <= 1'b1;
                    end
                    ST_STOP: if (w_tick) begin
                        if (w_stop_last) begin
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_stop_ph <= 1'b1;
                            if (r_stop == STOP_15) r_div_cnt <= w_half_m1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_frame_end)   r_flag <= 1'b1;
            else if (flag_clr) r_flag <= 1'b0;

            if (wr_en && full) r_ovf <= 1'b1;
            else if (flag_clr) r_ovf <= 1'b0;
        end
    end

    assign txd    = r_txd;
    assign active = r_active;
    assign flag   = r_flag;
    assign ovf    = r_ovf;
endmodule

// File: tb/tb_serial_xmit.sv
// Directed self-checking bench for serial_xmit (8-bit and 7-bit instances).
module tb_serial_xmit;
    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] a_div;
    logic [1:0]  a_stop, a_par;
    logic        a_wr, a_clr;
    logic [7:0]  a_data;
    logic        a_txd, a_active, a_full, a_empty, a_flag, a_ovf;

    logic [15:0] b_div;
    logic [1:0]  b_stop, b_par;
    logic        b_wr, b_clr;
    logic [6:0]  b_data;
    logic        b_txd, b_active, b_full, b_empty, b_flag, b_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    serial_xmit #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut8 (
        .clk(clk), .rst(rst), .baud_div(a_div), .stop_sel(a_stop), .parity_mode(a_par),
        .wr_en(a_wr), .wr_data(a_data), .flag_clr(a_clr), .txd(a_txd), .active(a_active),
        .full(a_full), .empty(a_empty), .flag(a_flag), .ovf(a_ovf));

    serial_xmit #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_W(16)) dut7 (
        .clk(clk), .rst(rst), .baud_div(b_div), .stop_sel(b_stop), .parity_mode(b_par),
        .wr_en(b_wr), .wr_data(b_data), .flag_clr(b_clr), .txd(b_txd), .active(b_active),
        .full(b_full), .empty(b_empty), .flag(b_flag), .ovf(b_ovf));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks txd holds value v for n cycles, advancing one clock per check.
    task automatic expect_txd(input string tag, input bit sel, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s txd c%0d", tag, i), sel ? b_txd : a_txd, v);
            tick();
        end
    endtask

    // par < 0 means no parity bit in the frame.
    task automatic frame(input string tag, input bit sel, input logic [7:0] d, input int nb,
                         input int bd1, input int par, input int stopc);
        expect_txd({tag, " start"}, sel, 1'b0, bd1);
        for (int i = 0; i < nb; i++) expect_txd($sformatf("%s d%0d", tag, i), sel, d[i], bd1);
        if (par >= 0) expect_txd({tag, " par"}, sel, par[0], bd1);
        expect_txd({tag, " stop"}, sel, 1'b1, stopc);
    endtask

    task automatic pulse_clr();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_div = 16'd3; a_stop = 2'b00; a_par = 2'b00; a_wr = 1'b0; a_clr = 1'b0; a_data = '0;
        b_div = 16'd1; b_stop = 2'b10; b_par = 2'b01; b_wr = 1'b0; b_clr = 1'b0; b_data = '0;
        repeat (2) tick();
        check("rst txd", a_txd, 1'b1);
        check("rst active", a_active, 1'b0);
        check("rst full", a_full, 1'b0);
        check("rst empty", a_empty, 1'b1);
        check("rst flag", a_flag, 1'b0);
        check("rst ovf", a_ovf, 1'b0);
        check("rst txd7", b_txd, 1'b1);
        rst = 1'b0;
        tick();

        // 8N1, baud_div=3, 0x55
        a_wr = 1'b1; a_data = 8'h55;
        tick();
        a_wr = 1'b0;
        check("8N1 empty after W", a_empty, 1'b0);
        check("8N1 txd idle after W", a_txd, 1'b1);
        tick();
        check("8N1 active", a_active, 1'b1);
        frame("8N1", 1'b0, 8'h55, 8, 4, -1, 3);
        check("8N1 flag early", a_flag, 1'b0);
        expect_txd("8N1 laststop", 1'b0, 1'b1, 1);
        check("8N1 flag", a_flag, 1'b1);
        check("8N1 active end", a_active, 1'b0);
        check("8N1 empty end", a_empty, 1'b1);
        pulse_clr();
        check("8N1 flag clr", a_flag, 1'b0);

        // 1.5 stop, odd parity, baud_div=4, 0x00; config changed mid-character
        a_div = 16'd4; a_stop = 2'b01; a_par = 2'b10; a_data = 8'h00; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        tick();
        a_div = 16'd9; a_stop = 2'b10; a_par = 2'b00;
        frame("8O1.5", 1'b0, 8'h00, 8, 5, 1, 6);
        check("8O1.5 flag early", a_flag, 1'b0);
        expect_txd("8O1.5 laststop", 1'b0, 1'b1, 1);
        check("8O1.5 flag", a_flag, 1'b1);
        check("8O1.5 active end", a_active, 1'b0);
        pulse_clr();

        // 7E2 on the 7-bit instance, baud_div=1, 0x03
        b_wr = 1'b1; b_data = 7'h03;
        tick();
        b_wr = 1'b0;
        tick();
        frame("7E2", 1'b1, 8'h03, 7, 2, 0, 3);
        check("7E2 flag early", b_flag, 1'b0);
        expect_txd("7E2 laststop", 1'b1, 1'b1, 1);
        check("7E2 flag", b_flag, 1'b1);
        check("7E2 active end", b_active, 1'b0);

        // FIFO full: one shifting, 5 more written back-to-back
        a_div = 16'd1; a_stop = 2'b00; a_par = 2'b00;
        a_wr = 1'b1; a_data = 8'hA1;
        tick();
        a_wr = 1'b0;
        tick();
        check("ff C0 txd start", a_txd, 1'b0);
        check("ff C0 popped", a_empty, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            a_wr = 1'b1;
            a_data = (k == 5) ? 8'h99 : 8'(k * 8'h11);
            tick();
            check($sformatf("ff full w%0d", k), a_full, (k >= 4) ? 1'b1 : 1'b0);
        end
        a_wr = 1'b0;
        check("ff ovf", a_ovf, 1'b1);
        check("ff empty while full", a_empty, 1'b0);
        repeat (14) tick();
        check("ff C0 last stop", a_txd, 1'b1);
        check("ff flag before C0 end", a_flag, 1'b0);
        tick();
        check("ff flag C0 end", a_flag, 1'b1);
        frame("ff C1", 1'b0, 8'h11, 8, 2, -1, 2);
        frame("ff C2", 1'b0, 8'h22, 8, 2, -1, 2);
        check("ff empty before C4", a_empty, 1'b0);
        frame("ff C3", 1'b0, 8'h33, 8, 2, -1, 2);
        check("ff empty after last pop", a_empty, 1'b1);
        check("ff not full", a_full, 1'b0);
        frame("ff C4", 1'b0, 8'h44, 8, 2, -1, 2);
        check("ff active end", a_active, 1'b0);
        expect_txd("ff no C5", 1'b0, 1'b1, 10);
        pulse_clr();
        check("ff flag clr", a_flag, 1'b0);
        check("ff ovf clr", a_ovf, 1'b0);

        // Flag collision: clear on the edge that ends the stop bit
        a_wr = 1'b1; a_data = 8'h0F;
        tick();
        a_wr = 1'b0;
        tick();
        check("col start", a_txd, 1'b0);
        repeat (19) tick();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("col flag set wins", a_flag, 1'b1);
        tick();
        check("col flag holds", a_flag, 1'b1);
        pulse_clr();
        check("col flag cleared", a_flag, 1'b0);

        // Reset mid-DATA (bit 3), second character buffered
        a_div = 16'd3;
        a_wr = 1'b1; a_data = 8'hF0;
        tick();
        a_data = 8'h0F;
        tick();
        a_wr = 1'b0;
        repeat (17) tick();
        check("rstmid bit3 pre", a_txd, 1'b0);
        check("rstmid empty pre", a_empty, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid txd async", a_txd, 1'b1);
        check("rstmid empty async", a_empty, 1'b1);
        check("rstmid active async", a_active, 1'b0);
        tick();
        rst = 1'b0;
        expect_txd("rstmid quiet", 1'b0, 1'b1, 30);
        check("rstmid active quiet", a_active, 1'b0);
        check("rstmid flag quiet", a_flag, 1'b0);
        a_wr = 1'b1; a_data = 8'h5A;
        tick();
        a_wr = 1'b0;
        tick();
        frame("rstmid next", 1'b0, 8'h5A, 8, 4, -1, 4);
        check("rstmid next flag", a_flag, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
